// File: rtl/axis2axi_in_if.sv
// Bundle of config, stream and AXI4 write-channel signals for the axis2axi_in bridge.
interface axis2axi_in_if #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned AXI_LEN_W  = 8,
    parameter int unsigned AXI_ID_W   = 1
);
    localparam int unsigned STRB_W = AXI_DATA_W / 8;

    // job configuration
    logic [AXI_ADDR_W-1:0] config_in_addr_i;
    logic [AXI_ADDR_W-1:0] config_in_length_i;
    logic                  config_in_valid_i;
    logic                  config_in_ready_o;

    // incoming stream
    logic [AXI_DATA_W-1:0] axis_in_data_i;
    logic                  axis_in_valid_i;
    logic                  axis_in_ready_o;

    logic                  error_o;

    // AW channel
    logic [AXI_ADDR_W-1:0] axi_awaddr_o;
    logic [AXI_LEN_W-1:0]  axi_awlen_o;
    logic                  axi_awvalid_o;
    logic                  axi_awready_i;
    logic [AXI_ID_W-1:0]   axi_awid_o;
    logic [2:0]            axi_awsize_o;
    logic [1:0]            axi_awburst_o;
    logic                  axi_awlock_o;
    logic [3:0]            axi_awcache_o;
    logic [2:0]            axi_awprot_o;
    logic [3:0]            axi_awqos_o;

    // W channel
    logic [AXI_DATA_W-1:0] axi_wdata_o;
    logic [STRB_W-1:0]     axi_wstrb_o;
    logic                  axi_wlast_o;
    logic                  axi_wvalid_o;
    logic                  axi_wready_i;

    // B channel
    logic [1:0]            axi_bresp_i;
    logic                  axi_bvalid_i;
    logic                  axi_bready_o;

    // bridge side
    modport master (
        input  config_in_addr_i, config_in_length_i, config_in_valid_i,
        output config_in_ready_o,
        input  axis_in_data_i, axis_in_valid_i,
        output axis_in_ready_o, error_o,
        output axi_awaddr_o, axi_awlen_o, axi_awvalid_o,
        input  axi_awready_i,
        output axi_awid_o, axi_awsize_o, axi_awburst_o, axi_awlock_o,
        output axi_awcache_o, axi_awprot_o, axi_awqos_o,
        output axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o,
        input  axi_wready_i,
        input  axi_bresp_i, axi_bvalid_i,
        output axi_bready_o
    );

    // environment side: job source, stream source and memory slave
    modport slave (
        output config_in_addr_i, config_in_length_i, config_in_valid_i,
        input  config_in_ready_o,
        output axis_in_data_i, axis_in_valid_i,
        input  axis_in_ready_o, error_o,
        input  axi_awaddr_o, axi_awlen_o, axi_awvalid_o,
        output axi_awready_i,
        input  axi_awid_o, axi_awsize_o, axi_awburst_o, axi_awlock_o,
        input  axi_awcache_o, axi_awprot_o, axi_awqos_o,
        input  axi_wdata_o, axi_wstrb_o, axi_wlast_o, axi_wvalid_o,
        output axi_wready_i,
        output axi_bresp_i, axi_bvalid_i,
        input  axi_bready_o
    );
endinterface

// File: rtl/axis2axi_in.sv
// AXI-Stream to AXI4 write-master bridge: buffers stream words and writes them
// as INCR bursts capped by BURST_SIZE, remaining length and 4KB pages.
module axis2axi_in #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned AXI_LEN_W  = 8,
    parameter int unsigned AXI_ID_W   = 1,
    parameter int unsigned BURST_W    = 4
) (
    input  logic          clk_i,
    input  logic          arst_n_i,
    axis2axi_in_if.master bus
);
    localparam int unsigned BURST_SIZE = 1 << BURST_W;
    localparam int unsigned FIFO_DEPTH = 1 << (BURST_W + 1);
    localparam int unsigned PTR_W      = BURST_W + 1;
    localparam int unsigned CNT_W      = BURST_W + 2;
    localparam int unsigned BEAT_W     = BURST_W + 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ADDR   = 3'd3;
    localparam logic [2:0] S_DATA   = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q;
    logic [AXI_ADDR_W-1:0] len_rem_q;
    logic [AXI_ADDR_W-1:0] in_rem_q;
    logic [BEAT_W-1:0]     burst_q;
    logic [AXI_LEN_W-1:0]  awlen_q;
    logic [BEAT_W-1:0]     beat_q;
    logic                  err_q;

    logic [AXI_DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  cfg_ready, aw_valid, b_ready, data_phase;
    logic                  cfg_fire, push, pop, last_beat, fifo_full, fifo_empty, in_ready;
    logic [AXI_ADDR_W-1:0] page_words, lim, len_rem_d;
    logic [BEAT_W-1:0]     burst_calc;

    // Words left on the current 4KB page; no page limit on narrow address buses
    if (AXI_ADDR_W >= 13) begin : g_page
        assign page_words = AXI_ADDR_W'((13'h1000 - {1'b0, addr_q[11:0]}) >> 2);
    end else begin : g_nopage
        assign page_words = AXI_ADDR_W'(BURST_SIZE);
    end

    // Next burst length: min of burst cap, remaining words and page room
    always_comb begin
        lim = AXI_ADDR_W'(BURST_SIZE);
        if (len_rem_q < lim) lim = len_rem_q;
        if (page_words < lim) lim = page_words;
    end
    assign burst_calc = BEAT_W'(lim);

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign in_ready   = (state_q != S_IDLE) && (in_rem_q != '0) && !fifo_full;
    assign cfg_fire   = bus.config_in_valid_i && cfg_ready;
    assign push       = bus.axis_in_valid_i && in_ready;
    assign pop        = data_phase && !fifo_empty && bus.axi_wready_i;
    assign last_beat  = (beat_q == (burst_q - BEAT_W'(1)));
    assign len_rem_d  = (len_rem_q > AXI_ADDR_W'(burst_q)) ? (len_rem_q - AXI_ADDR_W'(burst_q)) : '0;

    // State register
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state and per-state handshake decode
    always_comb begin
        state_d    = state_q;
        cfg_ready  = 1'b0;
        aw_valid   = 1'b0;
        b_ready    = 1'b0;
        data_phase = 1'b0;
        case (state_q)
            S_IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_fire && (bus.config_in_length_i != '0)) state_d = S_LAUNCH;
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (count_q >= CNT_W'(burst_q)) state_d = S_ADDR;
            end
            S_ADDR: begin
                aw_valid = 1'b1;
                if (bus.axi_awready_i) state_d = S_DATA;
            end
            S_DATA: begin
                data_phase = 1'b1;
                if (pop && last_beat) state_d = S_RESP;
            end
            S_RESP: begin
                b_ready = 1'b1;
                if (bus.axi_bvalid_i) state_d = (len_rem_d == '0) ? S_IDLE : S_LAUNCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Job counters, burst registers and sticky error
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            addr_q    <= '0;
            len_rem_q <= '0;
            in_rem_q  <= '0;
            burst_q   <= '0;
            awlen_q   <= '0;
            beat_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            if (cfg_fire) begin
                addr_q    <= bus.config_in_addr_i;
                len_rem_q <= bus.config_in_length_i;
                in_rem_q  <= bus.config_in_length_i;
                err_q     <= 1'b0;
            end
            if (push) in_rem_q <= in_rem_q - AXI_ADDR_W'(1);
            if (state_q == S_LAUNCH) begin
                burst_q <= burst_calc;
                awlen_q <= AXI_LEN_W'(burst_calc - BEAT_W'(1));
                beat_q  <= '0;
            end
            if (pop) beat_q <= beat_q + BEAT_W'(1);
            if (b_ready && bus.axi_bvalid_i) begin
                addr_q    <= addr_q + AXI_ADDR_W'({burst_q, 2'b00});
                len_rem_q <= len_rem_d;
                if (bus.axi_bresp_i != 2'b00) err_q <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are don't-care while the level is zero
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= bus.axis_in_data_i;
    end

    // FIFO pointers and level
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.config_in_ready_o = cfg_ready;
    assign bus.axis_in_ready_o   = in_ready;
    assign bus.error_o           = err_q;

    assign bus.axi_awaddr_o  = addr_q;
    assign bus.axi_awlen_o   = awlen_q;
    assign bus.axi_awvalid_o = aw_valid;
    assign bus.axi_awid_o    = AXI_ID_W'(0);
    assign bus.axi_awsize_o  = 3'd2;
    assign bus.axi_awburst_o = 2'd1;
    assign bus.axi_awlock_o  = 1'b0;
    assign bus.axi_awcache_o = 4'd2;
    assign bus.axi_awprot_o  = 3'd2;
    assign bus.axi_awqos_o   = 4'd0;

    assign bus.axi_wdata_o  = mem[rd_ptr_q];
    assign bus.axi_wstrb_o  = '1;
    assign bus.axi_wlast_o  = data_phase && last_beat;
    assign bus.axi_wvalid_o = data_phase && !fifo_empty;

    assign bus.axi_bready_o = b_ready;
endmodule

// File: tb/tb_axis2axi_in.sv
// Bench for axis2axi_in: stream source, randomised memory slave and a burst-level model.
module tb_axis2axi_in;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 8;
    localparam int unsigned IW = 1;
    localparam int unsigned BW = 4;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    axis2axi_in_if #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW)) bus ();

    axis2axi_in #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_LEN_W(LW), .AXI_ID_W(IW), .BURST_W(BW)) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    typedef struct { logic [31:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [31:0] data; logic last; } w_t;

    aw_t         exp_aw[$];
    w_t          exp_w[$];
    logic [31:0] job_data_q[$];
    logic [31:0] stream_q[$];
    logic [31:0] aw_log_addr[$];
    int          aw_log_len[$];
    int          w_beats;

    bit m_active, m_err, m_aw_done;
    int m_in_rem, m_bursts_left, m_beats_left, m_acc, m_written;

    int s_gap = 0, aw_gap = 0, w_gap = 0;
    int err_idx = -1;
    int b_count = 0;

    // Split a job into the bursts it must produce and the beats each one carries
    task automatic model_job(input logic [31:0] a0, input int len);
        logic [31:0] a;
        int rem, b, page;
        w_t w;
        a = a0;
        rem = len;
        while (rem > 0) begin
            page = (4096 - int'(a & 32'hFFF)) / 4;
            b = (rem > 16) ? 16 : rem;
            if (page < b) b = page;
            exp_aw.push_back('{a, 8'(b - 1)});
            for (int i = 0; i < b; i++) begin
                w.data = job_data_q.pop_front();
                w.last = (i == b - 1);
                exp_w.push_back(w);
            end
            a = a + 32'(4 * b);
            rem = rem - b;
            m_bursts_left++;
        end
    endtask

    // Cycle compare against the model, then advance it with the handshakes seen
    always @(negedge clk) begin
        if (arst_n) begin
            aw_t e;
            w_t ew;
            chk("config_ready", bus.config_in_ready_o, !m_active);
            chk("error", bus.error_o, m_err);
            if (bus.axis_in_ready_o) chk("stream_ready_with_words_left", m_in_rem > 0, 1);
            if (bus.axi_wvalid_o) begin
                chk("w_inside_burst", m_aw_done && m_beats_left > 0, 1);
                chk("wstrb", bus.axi_wstrb_o, 4'hF);
            end
            if (m_aw_done && m_beats_left > 0) chk("w_no_gap", bus.axi_wvalid_o, 1);
            if (bus.axi_awvalid_o) begin
                chk("aw_const", {bus.axi_awid_o, bus.axi_awsize_o, bus.axi_awburst_o, bus.axi_awlock_o,
                                 bus.axi_awcache_o, bus.axi_awprot_o, bus.axi_awqos_o},
                    {1'b0, 3'd2, 2'd1, 1'b0, 4'd2, 3'd2, 4'd0});
                chk("aw_while_idle_burst", m_aw_done, 0);
                if (exp_aw.size() > 0)
                    chk("aw_data_buffered", (m_acc - m_written) >= int'(exp_aw[0].len) + 1, 1);
            end

            if (bus.config_in_valid_i && bus.config_in_ready_o) begin
                m_err = 1'b0;
                if (bus.config_in_length_i != 0) begin
                    m_active  = 1'b1;
                    m_in_rem  = int'(bus.config_in_length_i);
                    m_acc     = 0;
                    m_written = 0;
                    model_job(bus.config_in_addr_i, int'(bus.config_in_length_i));
                end
            end
            if (bus.axis_in_valid_i && bus.axis_in_ready_o) begin
                m_in_rem--;
                m_acc++;
            end
            if (bus.axi_awvalid_o && bus.axi_awready_i) begin
                aw_log_addr.push_back(bus.axi_awaddr_o);
                aw_log_len.push_back(int'(bus.axi_awlen_o));
                if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
                else begin
                    e = exp_aw.pop_front();
                    chk("awaddr", bus.axi_awaddr_o, e.addr);
                    chk("awlen", bus.axi_awlen_o, e.len);
                end
                m_aw_done    = 1'b1;
                m_beats_left = int'(bus.axi_awlen_o) + 1;
            end
            if (bus.axi_wvalid_o && bus.axi_wready_i) begin
                w_beats++;
                m_written++;
                m_beats_left--;
                if (exp_w.size() == 0) chk("w_unexpected", 1, 0);
                else begin
                    ew = exp_w.pop_front();
                    chk("wdata", bus.axi_wdata_o, ew.data);
                    chk("wlast", bus.axi_wlast_o, ew.last);
                end
            end
            if (bus.axi_bvalid_i && bus.axi_bready_o) begin
                chk("b_after_last_beat", m_aw_done && m_beats_left == 0, 1);
                m_aw_done = 1'b0;
                if (bus.axi_bresp_i != 2'b00) m_err = 1'b1;
                m_bursts_left--;
                if (m_bursts_left <= 0) m_active = 1'b0;
            end
        end
    end

    // Stream source with optional valid gaps; valid is held until accepted
    initial begin
        bit f;
        bus.axis_in_valid_i = 1'b0;
        bus.axis_in_data_i  = '0;
        forever begin
            @(negedge clk);
            f = bus.axis_in_valid_i && bus.axis_in_ready_o;
            @(posedge clk);
            #1;
            if (f && stream_q.size() > 0) void'(stream_q.pop_front());
            if (bus.axis_in_valid_i && !f && stream_q.size() > 0) begin
                bus.axis_in_data_i = stream_q[0];
            end else if (stream_q.size() > 0 && int'($urandom_range(99)) >= s_gap) begin
                bus.axis_in_valid_i = 1'b1;
                bus.axis_in_data_i  = stream_q[0];
            end else begin
                bus.axis_in_valid_i = 1'b0;
            end
        end
    end

    // Memory slave: random AW/W backpressure, one B per burst after its last beat
    initial begin
        bit wl, bf, pend;
        bus.axi_awready_i = 1'b0;
        bus.axi_wready_i  = 1'b0;
        bus.axi_bvalid_i  = 1'b0;
        bus.axi_bresp_i   = 2'b00;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            wl = bus.axi_wvalid_o && bus.axi_wready_i && bus.axi_wlast_o;
            bf = bus.axi_bvalid_i && bus.axi_bready_o;
            @(posedge clk);
            #1;
            if (!arst_n) begin
                bus.axi_bvalid_i  = 1'b0;
                bus.axi_awready_i = 1'b0;
                bus.axi_wready_i  = 1'b0;
                pend = 1'b0;
            end else begin
                if (wl) pend = 1'b1;
                if (bf) begin
                    bus.axi_bvalid_i = 1'b0;
                    b_count++;
                end
                if (pend && !bus.axi_bvalid_i) begin
                    bus.axi_bvalid_i = 1'b1;
                    bus.axi_bresp_i  = (b_count == err_idx) ? 2'b10 : 2'b00;
                    pend = 1'b0;
                end
                bus.axi_awready_i = int'($urandom_range(99)) >= aw_gap;
                bus.axi_wready_i  = int'($urandom_range(99)) >= w_gap;
            end
        end
    end

    task automatic load_words(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            job_data_q.push_back(base + 32'(i));
            stream_q.push_back(base + 32'(i));
        end
    endtask

    task automatic run_cfg(input logic [31:0] a, input int len);
        int cyc;
        @(posedge clk);
        #1;
        bus.config_in_addr_i   = a;
        bus.config_in_length_i = 32'(len);
        bus.config_in_valid_i  = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.config_in_ready_o && cyc < 200);
        if (cyc >= 200) chk("config_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.config_in_valid_i = 1'b0;
    endtask

    task automatic wait_done();
        int cyc;
        cyc = 0;
        do begin
            @(posedge clk);
            #2;
            cyc++;
        end while ((m_active || exp_aw.size() > 0 || exp_w.size() > 0) && cyc < 4000);
        if (cyc >= 4000) chk("job_timeout", 0, 1);
    endtask

    task automatic clear_logs();
        aw_log_addr.delete();
        aw_log_len.delete();
        w_beats = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_config_ready"}, bus.config_in_ready_o, 1);
        chk({tag, "_axis_ready"},   bus.axis_in_ready_o, 0);
        chk({tag, "_awvalid"},      bus.axi_awvalid_o, 0);
        chk({tag, "_wvalid"},       bus.axi_wvalid_o, 0);
        chk({tag, "_wlast"},        bus.axi_wlast_o, 0);
        chk({tag, "_bready"},       bus.axi_bready_o, 0);
        chk({tag, "_error"},        bus.error_o, 0);
    endtask

    initial begin
        int cyc;
        bus.config_in_addr_i   = '0;
        bus.config_in_length_i = '0;
        bus.config_in_valid_i  = 1'b0;
        clear_logs();

        #22;
        check_reset_outputs("reset");
        @(posedge clk);
        #3;
        arst_n = 1'b1;

        // T1: one aligned 16-word burst, no backpressure
        clear_logs();
        load_words(16, 32'hA000_0000);
        run_cfg(32'h100, 16);
        wait_done();
        chk("t1_aw_count", aw_log_addr.size(), 1);
        chk("t1_aw0_addr", aw_log_addr[0], 32'h100);
        chk("t1_aw0_len", aw_log_len[0], 15);
        chk("t1_beats", w_beats, 16);
        chk("t1_config_ready", bus.config_in_ready_o, 1);

        // T2: split at the 4KB page boundary
        clear_logs();
        load_words(8, 32'hB000_0000);
        run_cfg(32'hFF8, 8);
        wait_done();
        chk("t2_aw_count", aw_log_addr.size(), 2);
        chk("t2_aw0_addr", aw_log_addr[0], 32'hFF8);
        chk("t2_aw0_len", aw_log_len[0], 1);
        chk("t2_aw1_addr", aw_log_addr[1], 32'h1000);
        chk("t2_aw1_len", aw_log_len[1], 5);

        // T3: zero-length job is consumed with no traffic
        clear_logs();
        for (int i = 0; i < 4; i++) stream_q.push_back(32'hDEAD_0000 + 32'(i));
        run_cfg(32'h500, 0);
        repeat (20) @(posedge clk);
        #2;
        chk("t3_aw_count", aw_log_addr.size(), 0);
        chk("t3_beats", w_beats, 0);
        chk("t3_stream_untouched", stream_q.size(), 4);
        chk("t3_config_ready", bus.config_in_ready_o, 1);
        stream_q.delete();
        repeat (2) @(posedge clk);

        // T4: 40 words with backpressure everywhere
        clear_logs();
        s_gap = 30; aw_gap = 40; w_gap = 30;
        load_words(40, 32'hC000_0000);
        run_cfg(32'h2000, 40);
        wait_done();
        chk("t4_aw_count", aw_log_addr.size(), 3);
        chk("t4_aw0_len", aw_log_len[0], 15);
        chk("t4_aw1_len", aw_log_len[1], 15);
        chk("t4_aw2_len", aw_log_len[2], 7);
        chk("t4_aw2_addr", aw_log_addr[2], 32'h2080);
        chk("t4_beats", w_beats, 40);

        // T5: SLVERR on the second of three bursts
        clear_logs();
        b_count = 0;
        err_idx = 1;
        load_words(40, 32'hD000_0000);
        run_cfg(32'h3000, 40);
        wait_done();
        err_idx = -1;
        chk("t5_aw_count", aw_log_addr.size(), 3);
        chk("t5_beats", w_beats, 40);
        chk("t5_error_sticky", bus.error_o, 1);

        // T6: reset in the middle of a burst with 5 beats left
        clear_logs();
        s_gap = 10; aw_gap = 20; w_gap = 50;
        load_words(40, 32'hE000_0000);
        run_cfg(32'h4000, 40);
        #1;
        chk("t6_error_cleared", bus.error_o, 0);
        cyc = 0;
        do begin
            @(posedge clk);
            #2;
            cyc++;
        end while (!(m_aw_done && m_beats_left == 5) && cyc < 2000);
        if (cyc >= 2000) chk("t6_reach_timeout", 0, 1);
        arst_n = 1'b0;
        #1;
        check_reset_outputs("t6_abort");
        exp_aw.delete();
        exp_w.delete();
        job_data_q.delete();
        stream_q.delete();
        m_active = 0; m_err = 0; m_aw_done = 0;
        m_in_rem = 0; m_bursts_left = 0; m_beats_left = 0; m_acc = 0; m_written = 0;
        repeat (2) @(posedge clk);
        #3;
        arst_n = 1'b1;
        repeat (2) @(posedge clk);

        clear_logs();
        load_words(20, 32'hF000_0000);
        run_cfg(32'h5FF0, 20);
        wait_done();
        chk("t6_aw_count", aw_log_addr.size(), 2);
        chk("t6_aw0_len", aw_log_len[0], 3);
        chk("t6_aw1_addr", aw_log_addr[1], 32'h6000);
        chk("t6_aw1_len", aw_log_len[1], 15);
        chk("t6_beats", w_beats, 20);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
